// File: rtl/nes_bus_pkg.sv
// +------------------------------------------------------------------+
// | nes_bus_pkg : shared arbiter state encoding, modes and helpers    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package nes_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN  = 2'd1,
      ST_GAP  = 2'd2
   } arb_state_e;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   // Ceiling log2; callers clamp the result to at least 1 bit.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/cpumc_arb_pick.sv
// +------------------------------------------------------------------+
// | cpumc_arb_pick : rotate / priority-encode / unrotate winner pick  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module cpumc_arb_pick #(
   parameter int N = 3,
   parameter int W = 2
) (
   input  logic [N-1:0] req_in,
   input  logic [W-1:0] start_in,
   output logic         valid_out,
   output logic [W-1:0] idx_out
);

   logic [N-1:0] rot;
   int           enc;

   always_comb begin
      rot       = '0;
      enc       = 0;
      valid_out = 1'b0;
      for (int k = 0; k < N; k++) begin
         rot[k] = req_in[(int'(start_in) + k) % N];
      end
      // Scan downward so the lowest rotated index is the one that sticks.
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) begin
            enc       = k;
            valid_out = 1'b1;
         end
      end
      idx_out = W'((enc + int'(start_in)) % N);
   end

endmodule

`default_nettype wire

// File: rtl/cpumc_arb.sv
// +------------------------------------------------------------------+
// | cpumc_arb : CPU / HCI / sprite-DMA bus arbiter with GAP handover  |
// | Optional starvation breaker: define CPUMC_ARB_STARVE_EN. Rev 1.0  |
// +------------------------------------------------------------------+
`default_nettype none

module cpumc_arb
   import nes_bus_pkg::*;
#(
   parameter int NUM_MASTERS  = 3,
   parameter int AW           = 16,
   parameter int DW           = 8,
   parameter int ARB_MODE     = 0,
   parameter int STARVE_LIMIT = 255,
   localparam int OW = (clog2(NUM_MASTERS) < 1) ? 1 : clog2(NUM_MASTERS)
) (
   input  logic                      clk_in,
   input  logic                      nrst_in,
   input  logic [NUM_MASTERS-1:0]    req_in,
   input  logic [NUM_MASTERS-1:0]    lock_in,
   input  logic [NUM_MASTERS*AW-1:0] a_in,
   input  logic [NUM_MASTERS-1:0]    r_nw_in,
   input  logic [NUM_MASTERS*DW-1:0] d_in,
   input  logic [DW-1:0]             bus_d_in,
   output logic [NUM_MASTERS-1:0]    rdy_out,
   output logic [AW-1:0]             a_out,
   output logic                      r_nw_out,
   output logic [DW-1:0]             d_out,
   output logic [DW-1:0]             rd_out,
   output logic [OW-1:0]             owner_out,
   output logic                      busy_out
);

   arb_state_e             state_q, state_d;
   logic [OW-1:0]          owner_q, owner_d;
   logic [OW-1:0]          ptr_q, ptr_d;
   logic [NUM_MASTERS-1:0] rdy_q, rdy_d;
   logic                   rst_done_q;

   logic [NUM_MASTERS-1:0] starve;
   logic [NUM_MASTERS-1:0] pick_req;
   logic [OW-1:0]          pick_start;
   logic [OW-1:0]          pick_idx;
   logic                   pick_valid;
   logic                   own_req, own_lock, eligible, grant;

   always_comb begin
      own_req  = 1'b0;
      own_lock = 1'b0;
      eligible = 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (owner_q == OW'(i)) begin
            own_req  = req_in[i];
            own_lock = lock_in[i];
         end else if (req_in[i] && (ARB_MODE == ARB_RR || i < int'(owner_q))) begin
            eligible = 1'b1;
         end
      end
   end

   // A starving master overrides the normal search and wins lowest-first.
   always_comb begin
      if (|starve) begin
         pick_req   = starve;
         pick_start = '0;
      end else begin
         pick_req   = req_in;
         pick_start = (ARB_MODE == ARB_RR) ? ptr_q : '0;
      end
   end

   cpumc_arb_pick #(
      .N (NUM_MASTERS),
      .W (OW)
   ) u_pick (
      .req_in    (pick_req),
      .start_in  (pick_start),
      .valid_out (pick_valid),
      .idx_out   (pick_idx)
   );

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      grant   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rst_done_q && pick_valid) grant = 1'b1;
         end
         ST_OWN: begin
            if (!own_req || (!own_lock && eligible) || (|starve)) begin
               state_d = (NUM_MASTERS == 1) ? ST_IDLE : ST_GAP;
            end
         end
         ST_GAP: begin
            if (pick_valid) grant   = 1'b1;
            else            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (grant) begin
         state_d = ST_OWN;
         owner_d = pick_idx;
         ptr_d   = (pick_idx == OW'(NUM_MASTERS - 1)) ? '0 : pick_idx + 1'b1;
      end
      for (int i = 0; i < NUM_MASTERS; i++) begin
         rdy_d[i] = (state_d == ST_OWN) && (owner_d == OW'(i));
      end
   end

   always_ff @(posedge clk_in or negedge nrst_in) begin
      if (!nrst_in) begin
         state_q    <= ST_IDLE;
         owner_q    <= '0;
         ptr_q      <= '0;
         rdy_q      <= '0;
         rst_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         ptr_q      <= ptr_d;
         rdy_q      <= rdy_d;
         rst_done_q <= 1'b1;
      end
   end

`ifdef CPUMC_ARB_STARVE_EN
   localparam int CW = (clog2(STARVE_LIMIT + 1) < 1) ? 1 : clog2(STARVE_LIMIT + 1);

   logic [CW-1:0] wait_q [NUM_MASTERS];
   logic [CW-1:0] wait_d [NUM_MASTERS];

   always_comb begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
         starve[i] = req_in[i] && !((state_q == ST_OWN) && (owner_q == OW'(i)))
                     && (wait_q[i] == CW'(STARVE_LIMIT));
         if (!req_in[i] || ((state_q == ST_OWN) && (owner_q == OW'(i)))
             || (grant && (owner_d == OW'(i)))) begin
            wait_d[i] = '0;
         end else if (wait_q[i] != CW'(STARVE_LIMIT)) begin
            wait_d[i] = wait_q[i] + 1'b1;
         end else begin
            wait_d[i] = wait_q[i];
         end
      end
   end

   always_ff @(posedge clk_in or negedge nrst_in) begin
      if (!nrst_in) begin
         for (int i = 0; i < NUM_MASTERS; i++) wait_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_MASTERS; i++) wait_q[i] <= wait_d[i];
      end
   end
`else
   logic unused_starve_limit;
   assign starve              = '0;
   assign unused_starve_limit = ^STARVE_LIMIT;
`endif

   // Bus is parked at read / address 0 whenever nobody holds a grant.
   always_comb begin
      a_out    = '0;
      r_nw_out = 1'b1;
      d_out    = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (rdy_q[i]) begin
            a_out    = a_in[i*AW +: AW];
            r_nw_out = r_nw_in[i];
            d_out    = d_in[i*DW +: DW];
         end
      end
   end

   assign rdy_out   = rdy_q;
   assign rd_out    = bus_d_in;
   assign owner_out = owner_q;
   assign busy_out  = (state_q == ST_OWN);

endmodule

`default_nettype wire

// File: tb/tb_cpumc_arb.sv
// +------------------------------------------------------------------+
// | tb_cpumc_arb : directed table + sequence bench for cpumc_arb      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_cpumc_arb;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic [2:0]  req = '0;
   logic [2:0]  lock = '0;
   logic [47:0] a_in = {16'hC002, 16'h4001, 16'h8000};
   logic [2:0]  r_nw_in = 3'b010;
   logic [23:0] d_in = {8'hD2, 8'hD1, 8'hD0};
   logic [7:0]  bus_d = 8'h5A;

   logic [2:0]  rdy0, rdy1;
   logic [15:0] a0, a1;
   logic        rnw0, rnw1, busy0, busy1;
   logic [7:0]  d0, d1, rd0, rd1;
   logic [1:0]  own0, own1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   cpumc_arb #(.ARB_MODE(0)) u_fix (
      .clk_in (clk), .nrst_in (nrst), .req_in (req), .lock_in (lock),
      .a_in (a_in), .r_nw_in (r_nw_in), .d_in (d_in), .bus_d_in (bus_d),
      .rdy_out (rdy0), .a_out (a0), .r_nw_out (rnw0), .d_out (d0),
      .rd_out (rd0), .owner_out (own0), .busy_out (busy0)
   );

   cpumc_arb #(.ARB_MODE(1)) u_rr (
      .clk_in (clk), .nrst_in (nrst), .req_in (req), .lock_in (lock),
      .a_in (a_in), .r_nw_in (r_nw_in), .d_in (d_in), .bus_d_in (bus_d),
      .rdy_out (rdy1), .a_out (a1), .r_nw_out (rnw1), .d_out (d1),
      .rd_out (rd1), .owner_out (own1), .busy_out (busy1)
   );

   typedef struct {
      logic [2:0] req;
      logic [2:0] lock;
      logic [2:0] exp0;
      logic [2:0] exp1;
   } vec_t;

   vec_t tbl [20];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] exp_a(input logic [2:0] g);
      case (g)
         3'b001:  return 16'h8000;
         3'b010:  return 16'h4001;
         3'b100:  return 16'hC002;
         default: return 16'h0000;
      endcase
   endfunction

   function automatic logic [7:0] exp_d(input logic [2:0] g);
      case (g)
         3'b001:  return 8'hD0;
         3'b010:  return 8'hD1;
         3'b100:  return 8'hD2;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic exp_rnw(input logic [2:0] g);
      return (g == 3'b010 || g == 3'b000);
   endfunction

   function automatic logic [1:0] exp_own(input logic [2:0] g);
      case (g)
         3'b010:  return 2'd1;
         3'b100:  return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      nrst = 1'b0;
      req  = '0;
      lock = '0;
      repeat (2) step();
      #3 nrst = 1'b1;
      step();
   endtask

   initial begin
      int first_cpu;
      int back_dma;

      tbl[0]  = '{3'b000, 3'b000, 3'b000, 3'b000};
      tbl[1]  = '{3'b000, 3'b000, 3'b000, 3'b000};
      tbl[2]  = '{3'b001, 3'b000, 3'b001, 3'b001};
      tbl[3]  = '{3'b011, 3'b000, 3'b001, 3'b000};
      tbl[4]  = '{3'b011, 3'b000, 3'b001, 3'b010};
      tbl[5]  = '{3'b010, 3'b000, 3'b000, 3'b010};
      tbl[6]  = '{3'b010, 3'b000, 3'b010, 3'b010};
      tbl[7]  = '{3'b011, 3'b010, 3'b010, 3'b010};
      tbl[8]  = '{3'b011, 3'b000, 3'b000, 3'b000};
      tbl[9]  = '{3'b111, 3'b000, 3'b001, 3'b100};
      tbl[10] = '{3'b111, 3'b000, 3'b001, 3'b000};
      tbl[11] = '{3'b111, 3'b000, 3'b001, 3'b001};
      tbl[12] = '{3'b000, 3'b000, 3'b000, 3'b000};
      tbl[13] = '{3'b000, 3'b000, 3'b000, 3'b000};
      tbl[14] = '{3'b110, 3'b000, 3'b010, 3'b010};
      tbl[15] = '{3'b110, 3'b010, 3'b010, 3'b010};
      tbl[16] = '{3'b100, 3'b010, 3'b000, 3'b000};
      tbl[17] = '{3'b100, 3'b000, 3'b100, 3'b100};
      tbl[18] = '{3'b000, 3'b000, 3'b000, 3'b000};
      tbl[19] = '{3'b000, 3'b000, 3'b000, 3'b000};

      // Reset values, and no grant on the first edge after release.
      nrst = 1'b0;
      req  = 3'b001;
      repeat (2) step();
      chk("rst_rdy",   rdy0, 3'b000);
      chk("rst_busy",  busy0, 1'b0);
      chk("rst_owner", own0, 2'd0);
      chk("rst_a",     a0, 16'h0000);
      chk("rst_rnw",   rnw0, 1'b1);
      chk("rst_d",     d0, 8'h00);
      #3 nrst = 1'b1;
      step();
      chk("post_rst_edge1_rdy", rdy0, 3'b000);
      step();
      chk("first_grant_rdy0", rdy0, 3'b001);
      chk("first_grant_rdy1", rdy1, 3'b001);
      chk("first_grant_a",    a0, 16'h8000);
      chk("first_grant_busy", busy0, 1'b1);
      chk("rd_broadcast",     rd0, 8'h5A);

      for (int i = 0; i < 20; i++) begin
         req  = tbl[i].req;
         lock = tbl[i].lock;
         step();
         chk($sformatf("v%0d_rdy_fix", i), rdy0, tbl[i].exp0);
         chk($sformatf("v%0d_rdy_rr", i),  rdy1, tbl[i].exp1);
         chk($sformatf("v%0d_busy", i),    busy0, |tbl[i].exp0);
         chk($sformatf("v%0d_a", i),       a0, exp_a(tbl[i].exp0));
         chk($sformatf("v%0d_rnw", i),     rnw0, exp_rnw(tbl[i].exp0));
         chk($sformatf("v%0d_d", i),       d0, exp_d(tbl[i].exp0));
         if (tbl[i].exp0 != 3'b000) chk($sformatf("v%0d_owner", i), own0, exp_own(tbl[i].exp0));
      end

      // Round-robin walk with all requests held: 0, gap, 1, gap, 2, gap, 0.
      do_reset();
      req = 3'b111;
      begin
         logic [2:0] rr_seq [7];
         rr_seq = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
         for (int i = 0; i < 7; i++) begin
            step();
            chk($sformatf("rr%0d_rdy", i), rdy1, rr_seq[i]);
            chk($sformatf("rr%0d_fix", i), rdy0, 3'b001);
         end
      end

      // Asynchronous reset in the middle of a CPU write.
      do_reset();
      req = 3'b001;
      step();
      chk("wr_rnw", rnw0, 1'b0);
      chk("wr_d",   d0, 8'hD0);
      #2 nrst = 1'b0;
      #1;
      chk("async_rnw",  rnw0, 1'b1);
      chk("async_rdy",  rdy0, 3'b000);
      chk("async_busy", busy0, 1'b0);
      chk("async_a",    a0, 16'h0000);
      #3 nrst = 1'b1;
      step();
      chk("async_rel_edge1", rdy0, 3'b000);
      step();
      chk("async_rel_edge2", rdy0, 3'b001);

      // DMA holds a locked grant while the CPU waits.
      do_reset();
      req  = 3'b100;
      lock = 3'b100;
      step();
      chk("dma_grant", rdy0, 3'b100);
      req       = 3'b101;
      first_cpu = 0;
      back_dma  = 0;
      for (int i = 1; i <= 600; i++) begin
         step();
         if (first_cpu == 0 && rdy0 == 3'b001) first_cpu = i;
         if (first_cpu != 0 && back_dma == 0 && rdy0 == 3'b100) back_dma = i;
      end
`ifdef CPUMC_ARB_STARVE_EN
      chk("starve_cpu_win_cycle", first_cpu, 257);
      chk("starve_dma_back_cycle", back_dma, 513);
`else
      chk("lock_cpu_never_won", first_cpu, 0);
      chk("lock_dma_still_owns", rdy0, 3'b100);
`endif
      req  = 3'b001;
      lock = 3'b000;
      step();
      chk("release_gap", rdy0, 3'b000);
      step();
      chk("release_cpu", rdy0, 3'b001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/cpumc_arb.md
CPUMC_ARB -- requirements
Module: cpumc_arb

Interface
REQ-001 SHALL expose parameter NUM_MASTERS, default 3, number of bus masters; index 0 is the CPU, 1 is HCI, 2 is sprite DMA.
REQ-002 SHALL expose parameter AW, default 16, address width.
REQ-003 SHALL expose parameter DW, default 8, data width.
REQ-004 SHALL expose parameter ARB_MODE, default 0, arbitration mode: 0 is fixed priority (lowest index wins), 1 is round-robin.
REQ-005 SHALL expose parameter STARVE_LIMIT, default 255, maximum number of cycles a requester waits (used only with CPUMC_ARB_STARVE_EN).
REQ-006 Port clk_in, input, 1, sole clock.
REQ-007 Port nrst_in, input, 1, reset, asynchronous, active-low.
REQ-008 Port req_in, input, NUM_MASTERS, per-master bus request.
REQ-009 Port lock_in, input, NUM_MASTERS, owner keeps the bus while its bit is set.
REQ-010 Port a_in, input, NUM_MASTERS*AW, packed master addresses; master i occupies bits [i*AW +: AW].
REQ-011 Port r_nw_in, input, NUM_MASTERS, per-master read/not-write.
REQ-012 Port d_in, input, NUM_MASTERS*DW, packed master write data.
REQ-013 Port bus_d_in, input, DW, merged slave read data.
REQ-014 Port rdy_out, output, NUM_MASTERS, registered one-hot grant that the master uses as its ready/stall signal.
REQ-015 Port a_out, r_nw_out, d_out, output, AW/1/DW, shared bus driven by the owner.
REQ-016 Port rd_out, output, DW, bus_d_in broadcast to all masters.
REQ-017 Port owner_out, output, clog2(NUM_MASTERS) (minimum 1), index of the current owner; valid while busy_out is high.
REQ-018 Port busy_out, output, 1, high in OWN state.

Function
REQ-019 SHALL implement a three-state FSM:
- IDLE: no owner.
- OWN: a master is granted.
- GAP: one-cycle dead cycle between owners.
REQ-020 IDLE->OWN SHALL occur on the first edge with any req_in set; rdy_out of the winner SHALL go high one cycle after its request is sampled.
REQ-021 OWN->GAP SHALL occur when:
- the owner's req_in is low (lock_in is ignored without req); or
- lock_in of the owner is low and another master is eligible to win.
REQ-022 In ARB_MODE 0, only a lower-index requester is eligible to preempt the owner; in ARB_MODE 1, any other requester is eligible.
REQ-023 GAP SHALL last exactly one cycle and then go to OWN with the new winner, or to IDLE if no request is pending; handover latency is therefore 2 cycles.
REQ-024 In IDLE and GAP:
- a_out SHALL be 0;
- r_nw_out SHALL be 1;
- d_out SHALL be 0;
- rdy_out SHALL be all zero.
No write can occur during a handover.
REQ-025 a_out, r_nw_out and d_out SHALL be a combinational mux of the owner's inputs, selected by the registered grant.
REQ-026 Round-robin: after granting master i, the search SHALL start at (i+1) mod NUM_MASTERS, wrapping from NUM_MASTERS-1 to 0; the pointer SHALL advance only on a grant.
REQ-027 If several requests arrive on the same edge, exactly one grant SHALL be issued per the mode rule; rdy_out SHALL never have more than one bit set.
REQ-028 With NUM_MASTERS=1, the FSM SHALL move only between IDLE and OWN; GAP is unreachable.
REQ-029 A request that drops in the same cycle it would be granted SHALL be treated as absent; the winner is chosen from the sampled req_in only.

Reset
REQ-030 While nrst_in is low:
- state SHALL be IDLE;
- rdy_out SHALL be 0;
- busy_out SHALL be 0;
- owner_out SHALL be 0;
- the round-robin pointer SHALL be 0;
- starvation counters SHALL be 0;
- the bus SHALL be driven with the REQ-024 idle values.
REQ-031 Reset asserted during OWN or GAP SHALL take effect immediately (asynchronously); the first grant after release occurs no earlier than the second clk_in edge.

Configuration
REQ-032 Macro CPUMC_ARB_STARVE_EN, when defined:
- each non-owner requester keeps a saturating wait counter, cleared when it is granted or when its req drops;
- when a counter reaches STARVE_LIMIT, the owner SHALL be forced to GAP on the next edge even if lock_in is high;
- that master SHALL then win, lowest index first on ties.
REQ-033 When CPUMC_ARB_STARVE_EN is undefined, no counters SHALL exist and lock_in SHALL be honoured indefinitely.

Structure
REQ-034 The following SHALL live in shared package nes_bus_pkg:
- state encoding constants ST_IDLE, ST_OWN, ST_GAP;
- ARB_FIXED and ARB_RR mode constants;
- clog2 helper function.
REQ-035 Winner selection SHALL be a sub-module, cpumc_arb_pick (a rotate, priority-encode and unrotate unit), shared by both modes.

Verification
REQ-036 Bench SHALL cover each of the following directed scenarios.
- Reset, then req_in=3'b001 -> rdy_out=3'b001 one cycle later; a_out follows a_in[15:0]=16'h8000.
- Mode 0, CPU owns, HCI req with lock low -> no preemption; CPU req drops -> one GAP cycle with a_out=0 and r_nw_out=1, then rdy_out=3'b010.
- Mode 1, all three req held, no lock -> grant sequence 0,1,2,0 with a GAP between each; pointer wraps.
- DMA lock_in=1 for 600 cycles, CPU req, STARVE_LIMIT=255:
  - macro defined -> DMA is forced off after 255 waiting cycles;
  - macro undefined -> CPU waits the full 600 cycles.
- nrst_in pulsed low mid-OWN during a write (r_nw_out=0) -> r_nw_out=1 and rdy_out=0 within the same cycle, asynchronously.
